// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate controller: operation
// encodings, FSM state type, datapath sizes and stage-index helpers.
package shift_pkg;

    localparam int unsigned DataW     = 16;
    localparam int unsigned NumStages = 4;

    localparam logic [1:0] OP_ROL = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_ROR = 2'b10;
    localparam logic [1:0] OP_SRA = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Bits of cnt strictly below stage k (the stages still to be visited).
    function automatic logic [3:0] lower_mask(logic [1:0] k);
        lower_mask = (4'd1 << k) - 4'd1;
    endfunction

    // Index of the highest set bit; only meaningful for v != 0.
    function automatic logic [1:0] msb_idx(logic [3:0] v);
        if (v[3])      msb_idx = 2'd3;
        else if (v[2]) msb_idx = 2'd2;
        else if (v[1]) msb_idx = 2'd1;
        else           msb_idx = 2'd0;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel stage: shifts/rotates by 2^k. The SRA fill bit is
// supplied externally so every stage fills with the original operand sign.
module shift_stage
    import shift_pkg::*;
(
    input  logic [15:0] data_i,
    input  logic [1:0]  k_i,
    input  logic [1:0]  op_i,
    input  logic        sign_i,
    output logic [15:0] data_o
);

    logic [4:0]  amt;
    logic [31:0] rol_w;
    logic [31:0] ror_w;
    logic [31:0] sra_w;

    // Doubled operands make wrap-around and sign fill plain logical shifts.
    always_comb begin
        amt    = 5'd1 << k_i;
        rol_w  = {data_i, data_i} << amt;
        ror_w  = {data_i, data_i} >> amt;
        sra_w  = {{16{sign_i}}, data_i} >> amt;
        data_o = data_i;
        unique case (op_i)
            OP_ROL:  data_o = rol_w[31:16];
            OP_SLL:  data_o = data_i << amt;
            OP_ROR:  data_o = ror_w[15:0];
            OP_SRA:  data_o = sra_w[15:0];
            default: data_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Sequential shift/rotate controller: one shift_stage reused over up to four
// RUN cycles (amounts 8, 4, 2, 1), valid/ready handshakes on both sides.
// Define SHIFT_SEQ_SKIP_EN to skip RUN cycles for zero bits of the count.
module shift_seq_ctrl
    import shift_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_data,
    input  logic [3:0]  in_cnt,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        busy
);

    state_e      state_q, state_d;
    logic [1:0]  k_q, k_d;
    logic [15:0] work_q, work_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [15:0] stage_out;

    shift_stage u_stage (
        .data_i (work_q),
        .k_i    (k_q),
        .op_i   (op_q),
        .sign_i (sign_q),
        .data_o (stage_out)
    );

    // State register; reset overrides any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd3;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            sign_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            sign_q  <= sign_d;
        end
    end

    // Next-state: capture in IDLE, one stage per RUN cycle, hold in DONE.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        sign_d  = sign_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    work_d = in_data;
                    cnt_d  = in_cnt;
                    op_d   = in_op;
                    sign_d = in_data[15];
`ifdef SHIFT_SEQ_SKIP_EN
                    if (in_cnt == 4'd0) begin
                        state_d = DONE;
                        k_d     = 2'd3;
                    end else begin
                        state_d = RUN;
                        k_d     = msb_idx(in_cnt);
                    end
`else
                    state_d = RUN;
                    k_d     = 2'd3;
`endif
                end
            end
            RUN: begin
                if (cnt_q[k_q]) work_d = stage_out;
`ifdef SHIFT_SEQ_SKIP_EN
                if ((cnt_q & lower_mask(k_q)) == 4'd0) begin
                    state_d = DONE;
                    k_d     = 2'd3;
                end else begin
                    k_d = msb_idx(cnt_q & lower_mask(k_q));
                end
`else
                // k wraps 0 -> 3, leaving it ready for the next request.
                k_d = k_q - 2'd1;
                if (k_q == 2'd0) state_d = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the state; result gated to zero when not valid.
    always_comb begin
        in_ready  = (state_q == IDLE);
        busy      = (state_q != IDLE);
        out_valid = (state_q == DONE);
        out_data  = out_valid ? work_q : 16'h0000;
    end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl; expected latency follows SHIFT_SEQ_SKIP_EN.
module tb_shift_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = '0;
    logic [3:0]  in_cnt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    shift_seq_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_cnt    (in_cnt),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'hABCD;
        in_cnt   = 4'h3;
        tick();
        tick();
        n_vec++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        n_vec++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        n_vec++;
        if (out_data !== 16'h0000) begin
            n_err++; $display("FAIL reset_out_data got %h want 0000", out_data);
        end
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL reset_busy got %b want 0", busy);
        end
        in_valid = 1'b0;
        rst      = 1'b0;
        tick();
    endtask

    // Issue one request, check latency and result, optionally hold out_ready
    // low for `hold` cycles, then release with a competing in_valid.
    task automatic run_op(input logic [15:0] d, input logic [3:0] c, input logic [1:0] o,
                          input logic [15:0] exp, input int hold, input string name);
        int edges;
        int exp_lat;
        bit gate_ok;
`ifdef SHIFT_SEQ_SKIP_EN
        exp_lat = $countones(c) + 1;
`else
        exp_lat = 5;
`endif
        gate_ok  = 1'b1;
        in_data  = d;
        in_cnt   = c;
        in_op    = o;
        in_valid = 1'b1;
        tick();
        edges    = 1;
        in_valid = 1'b0;
        in_data  = ~d;
        in_cnt   = ~c;
        in_op    = ~o;
        while (!out_valid && edges < 20) begin
            if (out_data !== 16'h0000 || busy !== 1'b1) gate_ok = 1'b0;
            tick();
            edges++;
        end
        n_vec++;
        if (edges != exp_lat) begin
            n_err++; $display("FAIL %s_latency got %0d want %0d", name, edges, exp_lat);
        end
        n_vec++;
        if (out_data !== exp) begin
            n_err++; $display("FAIL %s_data got %h want %h", name, out_data, exp);
        end
        n_vec++;
        if (!gate_ok) begin
            n_err++; $display("FAIL %s_idle_outputs got nonzero data or busy=0 want 0000/1", name);
        end
        for (int i = 0; i < hold; i++) begin
            tick();
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
                n_err++;
                $display("FAIL %s_hold%0d got v=%b d=%h rdy=%b want v=1 d=%h rdy=0",
                         name, i, out_valid, out_data, in_ready, exp);
            end
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_release got rdy=%b busy=%b v=%b want 1 0 0",
                     name, in_ready, busy, out_valid);
        end
    endtask

    task automatic test_basic_ops();
        run_op(16'h1234, 4'd4,  2'b00, 16'h2341, 0, "rol4");
        run_op(16'h00FF, 4'd8,  2'b01, 16'hFF00, 0, "sll8");
        run_op(16'h0001, 4'd1,  2'b10, 16'h8000, 0, "ror1");
        run_op(16'h8000, 4'd15, 2'b11, 16'hFFFF, 0, "sra15_neg");
        run_op(16'h4000, 4'd15, 2'b11, 16'h0000, 0, "sra15_pos");
        run_op(16'h8001, 4'd15, 2'b00, 16'hC000, 0, "rol15");
        run_op(16'hF000, 4'd3,  2'b11, 16'hFE00, 0, "sra3");
        run_op(16'h1234, 4'd4,  2'b10, 16'h4123, 0, "ror4");
        run_op(16'hFFFF, 4'd15, 2'b01, 16'h8000, 0, "sll15");
    endtask

    task automatic test_cnt_patterns();
        run_op(16'hBEEF, 4'd0,  2'b10, 16'hBEEF, 0, "cnt0");
        run_op(16'h1234, 4'hA,  2'b00, 16'hD048, 0, "rol10");
    endtask

    task automatic test_backpressure();
        run_op(16'h00FF, 4'd8, 2'b01, 16'hFF00, 3, "bp");
    endtask

    task automatic test_reset_mid_op();
        bit seen;
        seen     = 1'b0;
        in_data  = 16'h5555;
        in_cnt   = 4'hF;
        in_op    = 2'b00;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0) begin
            n_err++;
            $display("FAIL midrst got rdy=%b v=%b busy=%b d=%h want 1 0 0 0000",
                     in_ready, out_valid, busy, out_data);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_vec++;
        if (seen) begin
            n_err++; $display("FAIL midrst_no_result got out_valid=1 want 0");
        end
        run_op(16'h0F0F, 4'd4, 2'b10, 16'hF0F0, 0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic_ops();
        test_cnt_patterns();
        test_backpressure();
        test_reset_mid_op();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
